multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/rv_pkg.sv | 36 +++
 rtl/opclass_dec.sv | 22 ++
 rtl/multicycle_ctrl.sv | 134 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types and opcode constants for the multicycle instruction-sequencing controller.
package rv_pkg;

    // Controller states; the encoding is visible on the state output.
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    // Instruction class captured in DECODE and used by every later state.
    typedef enum logic [2:0] {
        OC_NONE,
        OC_ALU,
        OC_LOAD,
        OC_STORE,
        OC_BRANCH,
        OC_JUMP,
        OC_UPPER
    } opclass_t;

    // Major opcodes, instr[6:0].
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/opclass_dec.sv
// Pure combinational map from major opcode to instruction class.
module opclass_dec
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   opclass
);

    // Anything not listed is unsupported and reported as OC_NONE.
    always_comb begin
        case (opcode)
            OP_REG, OP_IMM:    opclass = OC_ALU;
            OP_LOAD:           opclass = OC_LOAD;
            OP_STORE:          opclass = OC_STORE;
            OP_BRANCH:         opclass = OC_BRANCH;
            OP_JAL, OP_JALR:   opclass = OC_JUMP;
            OP_LUI, OP_AUIPC:  opclass = OC_UPPER;
            default:           opclass = OC_NONE;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/mem/writeback sequencing,
// retired-instruction counter and sticky illegal-opcode flag.
module multicycle_ctrl
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic [6:0]  opcode,
    input  logic        halt_req,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_re,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    state_t      state_q, state_d;
    opclass_t    class_q, class_d;
    opclass_t    dec_class;
    logic        illegal_q, illegal_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;

    opclass_dec u_opclass_dec (
        .opcode  (opcode),
        .opclass (dec_class)
    );

    // State, captured class, sticky flag and counter registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_FETCH;
            class_q   <= OC_NONE;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic and strobes; retire is shared by BRANCH, STORE and WB.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value held and infer a latch.
        state_d   = state_q;
        class_d   = class_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        imem_re   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_re = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                class_d = dec_class;
                if (dec_class == OC_NONE) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (class_q)
                    OC_BRANCH:         retire  = 1'b1;
                    OC_LOAD, OC_STORE: state_d = S_MEM;
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (class_q == OC_LOAD) begin
                    dmem_re = 1'b1;
                    if (dmem_ready) state_d = S_WB;
                end else begin
                    dmem_we = 1'b1;
                    if (dmem_ready) retire = 1'b1;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                retire = 1'b1;
            end
            S_HALT: begin
                if (!halt_req && !illegal_q) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Retire boundary: the only place a pending halt request is honoured.
        if (retire) begin
            pc_we   = 1'b1;
            state_d = halt_req ? S_HALT : S_FETCH;
        end

        instret_d = instret_q + {31'd0, retire};

        // NOTE: strobes are gated by the asynchronous reset itself so they drop
        // the moment n_rst falls, without waiting for a clock edge.
        if (!n_rst) begin
            imem_re = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            rf_we   = 1'b0;
            dmem_re = 1'b0;
            dmem_we = 1'b0;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

    localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2,
                           ST_M = 3'd3, ST_W = 3'd4, ST_H = 3'd5;
    localparam logic [6:0] ALU = 7'b0110011, LD = 7'b0000011, ST = 7'b0100011,
                           BR  = 7'b1100011, BAD = 7'b1111111;

    logic        clk, n_rst, halt_req, imem_ready, dmem_ready;
    logic [6:0]  opcode;
    logic        imem_re, ir_we, pc_we, rf_we, dmem_re, dmem_we, illegal;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [5:0]  strobes;
    int          tests_run, tests_failed;

    assign strobes = {imem_re, ir_we, pc_we, rf_we, dmem_re, dmem_we};

    multicycle_ctrl dut (
        .clk(clk), .n_rst(n_rst), .opcode(opcode), .halt_req(halt_req),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_re(imem_re), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
        .dmem_re(dmem_re), .dmem_we(dmem_we), .state(state),
        .illegal(illegal), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus expectation: {opcode, imem_ready, dmem_ready, halt_req, state, strobes}.
    function automatic logic [18:0] v(input logic [6:0] op, input logic ir, input logic dr,
                                      input logic hr, input logic [2:0] st, input logic [5:0] sb);
        return {op, ir, dr, hr, st, sb};
    endfunction

    task automatic test_reset();
        n_rst = 1'b0; opcode = ALU; halt_req = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        #2;
        tests_run++;
        if ({state, illegal, instret} !== {ST_F, 1'b0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: got st=%0d ill=%b ir=%0d want st=0 ill=0 ir=0", state, illegal, instret);
        end
        @(posedge clk); #1;
        tests_run++;
        if (strobes !== 6'b000000) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b want 000000", strobes);
        end
        imem_ready = 1'b0;
        n_rst = 1'b1;
        #1;
        tests_run++;
        if ({state, strobes} !== {ST_F, 6'b100000}) begin
            tests_failed++;
            $display("FAIL reset_release: got %0d/%b want 0/100000", state, strobes);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        logic [18:0] seq [4];
        seq[0] = v(ALU, 1, 1, 0, ST_F, 6'b110000);
        seq[1] = v(ALU, 1, 1, 0, ST_D, 6'b000000);
        seq[2] = v(ALU, 1, 1, 0, ST_E, 6'b000000);
        seq[3] = v(ALU, 1, 1, 0, ST_W, 6'b001100);
        for (int i = 0; i < 4; i++) begin
            {opcode, imem_ready, dmem_ready, halt_req} = seq[i][18:9];
            #1;
            tests_run++;
            if ({state, strobes} !== seq[i][8:0]) begin
                tests_failed++;
                $display("FAIL alu[%0d]: got %0d/%b want %0d/%b", i, state, strobes, seq[i][8:6], seq[i][5:0]);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if ({state, instret} !== {ST_F, 32'd1}) begin
            tests_failed++;
            $display("FAIL alu_retire: got st=%0d instret=%0d want st=0 instret=1", state, instret);
        end
    endtask

    task automatic test_load_wait();
        logic [18:0] seq [8];
        int re_cnt = 0;
        seq[0] = v(LD, 1, 0, 0, ST_F, 6'b110000);
        seq[1] = v(LD, 1, 0, 0, ST_D, 6'b000000);
        seq[2] = v(LD, 1, 0, 0, ST_E, 6'b000000);
        seq[3] = v(LD, 1, 0, 0, ST_M, 6'b000010);
        seq[4] = v(LD, 1, 0, 0, ST_M, 6'b000010);
        seq[5] = v(LD, 1, 0, 0, ST_M, 6'b000010);
        seq[6] = v(LD, 1, 1, 0, ST_M, 6'b000010);
        seq[7] = v(LD, 1, 1, 0, ST_W, 6'b001100);
        for (int i = 0; i < 8; i++) begin
            {opcode, imem_ready, dmem_ready, halt_req} = seq[i][18:9];
            #1;
            if (dmem_re) re_cnt++;
            tests_run++;
            if ({state, strobes} !== seq[i][8:0]) begin
                tests_failed++;
                $display("FAIL load[%0d]: got %0d/%b want %0d/%b", i, state, strobes, seq[i][8:6], seq[i][5:0]);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if ({re_cnt, instret} !== {32'd4, 32'd2}) begin
            tests_failed++;
            $display("FAIL load_retire: got re_cycles=%0d instret=%0d want 4/2", re_cnt, instret);
        end
    endtask

    // Opcode is corrupted after DECODE of the store; the captured class must carry it.
    task automatic test_branch_store();
        logic [18:0] seq [8];
        seq[0] = v(BR,  1, 1, 0, ST_F, 6'b110000);
        seq[1] = v(BR,  1, 1, 0, ST_D, 6'b000000);
        seq[2] = v(BR,  1, 1, 0, ST_E, 6'b001000);
        seq[3] = v(ST,  1, 0, 0, ST_F, 6'b110000);
        seq[4] = v(ST,  1, 0, 0, ST_D, 6'b000000);
        seq[5] = v(BAD, 1, 0, 0, ST_E, 6'b000000);
        seq[6] = v(BAD, 1, 0, 0, ST_M, 6'b000001);
        seq[7] = v(BAD, 1, 1, 0, ST_M, 6'b001001);
        for (int i = 0; i < 8; i++) begin
            {opcode, imem_ready, dmem_ready, halt_req} = seq[i][18:9];
            #1;
            tests_run++;
            if ({state, strobes} !== seq[i][8:0]) begin
                tests_failed++;
                $display("FAIL br_st[%0d]: got %0d/%b want %0d/%b", i, state, strobes, seq[i][8:6], seq[i][5:0]);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if ({state, illegal, instret} !== {ST_F, 1'b0, 32'd4}) begin
            tests_failed++;
            $display("FAIL br_st_retire: got st=%0d ill=%b instret=%0d want 0/0/4", state, illegal, instret);
        end
    endtask

    task automatic test_halt_boundary();
        logic [18:0] seq [8];
        seq[0] = v(LD, 1, 1, 0, ST_F, 6'b110000);
        seq[1] = v(LD, 1, 1, 0, ST_D, 6'b000000);
        seq[2] = v(LD, 1, 1, 1, ST_E, 6'b000000);
        seq[3] = v(LD, 1, 1, 1, ST_M, 6'b000010);
        seq[4] = v(LD, 1, 1, 1, ST_W, 6'b001100);
        seq[5] = v(LD, 1, 1, 1, ST_H, 6'b000000);
        seq[6] = v(LD, 0, 1, 0, ST_H, 6'b000000);
        seq[7] = v(LD, 0, 1, 0, ST_F, 6'b100000);
        for (int i = 0; i < 8; i++) begin
            {opcode, imem_ready, dmem_ready, halt_req} = seq[i][18:9];
            #1;
            tests_run++;
            if ({state, strobes} !== seq[i][8:0]) begin
                tests_failed++;
                $display("FAIL halt[%0d]: got %0d/%b want %0d/%b", i, state, strobes, seq[i][8:6], seq[i][5:0]);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (instret !== 32'd5) begin
            tests_failed++;
            $display("FAIL halt_instret: got %0d want 5", instret);
        end
    endtask

    task automatic test_illegal();
        logic [18:0] seq [12];
        seq[0] = v(BAD, 1, 0, 0, ST_F, 6'b110000);
        seq[1] = v(BAD, 0, 0, 0, ST_D, 6'b000000);
        for (int i = 2; i < 12; i++) seq[i] = v(ALU, 1, 1, 0, ST_H, 6'b000000);
        for (int i = 0; i < 12; i++) begin
            {opcode, imem_ready, dmem_ready, halt_req} = seq[i][18:9];
            #1;
            tests_run++;
            if ({state, strobes} !== seq[i][8:0]) begin
                tests_failed++;
                $display("FAIL illegal[%0d]: got %0d/%b want %0d/%b", i, state, strobes, seq[i][8:6], seq[i][5:0]);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if ({state, illegal, instret} !== {ST_H, 1'b1, 32'd5}) begin
            tests_failed++;
            $display("FAIL illegal_sticky: got st=%0d ill=%b instret=%0d want 5/1/5", state, illegal, instret);
        end
        imem_ready = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        tests_run++;
        if ({state, illegal, instret, strobes} !== {ST_F, 1'b0, 32'd0, 6'b000000}) begin
            tests_failed++;
            $display("FAIL illegal_reset: got st=%0d ill=%b instret=%0d sb=%b want 0/0/0/000000",
                     state, illegal, instret, strobes);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        logic [18:0] seq [3];
        imem_ready = 1'b0;
        @(negedge clk);
        force dut.instret_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.instret_q;
        @(posedge clk); #1;
        tests_run++;
        if ({state, instret} !== {ST_F, 32'hFFFF_FFFF}) begin
            tests_failed++;
            $display("FAIL wrap_preload: got st=%0d instret=%h want 0/ffffffff", state, instret);
        end
        seq[0] = v(BR, 1, 1, 0, ST_F, 6'b110000);
        seq[1] = v(BR, 1, 1, 0, ST_D, 6'b000000);
        seq[2] = v(BR, 1, 1, 0, ST_E, 6'b001000);
        for (int i = 0; i < 3; i++) begin
            {opcode, imem_ready, dmem_ready, halt_req} = seq[i][18:9];
            #1;
            tests_run++;
            if ({state, strobes} !== seq[i][8:0]) begin
                tests_failed++;
                $display("FAIL wrap[%0d]: got %0d/%b want %0d/%b", i, state, strobes, seq[i][8:6], seq[i][5:0]);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (instret !== 32'd0) begin
            tests_failed++;
            $display("FAIL wrap_instret: got %h want 00000000", instret);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [18:0] seq [4];
        seq[0] = v(ST, 1, 0, 0, ST_F, 6'b110000);
        seq[1] = v(ST, 1, 0, 0, ST_D, 6'b000000);
        seq[2] = v(ST, 1, 0, 0, ST_E, 6'b000000);
        seq[3] = v(ST, 1, 0, 0, ST_M, 6'b000001);
        for (int i = 0; i < 4; i++) begin
            {opcode, imem_ready, dmem_ready, halt_req} = seq[i][18:9];
            #1;
            tests_run++;
            if ({state, strobes} !== seq[i][8:0]) begin
                tests_failed++;
                $display("FAIL rst_mem[%0d]: got %0d/%b want %0d/%b", i, state, strobes, seq[i][8:6], seq[i][5:0]);
            end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        dmem_ready = 1'b1;
        #2;
        n_rst = 1'b0;
        #1;
        tests_run++;
        if ({state, strobes, instret} !== {ST_F, 6'b000000, 32'd0}) begin
            tests_failed++;
            $display("FAIL rst_mem_async: got st=%0d sb=%b instret=%0d want 0/000000/0", state, strobes, instret);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({state, instret} !== {ST_F, 32'd0}) begin
            tests_failed++;
            $display("FAIL rst_mem_hold: got st=%0d instret=%0d want 0/0", state, instret);
        end
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_alu();
        test_load_wait();
        test_branch_store();
        test_halt_boundary();
        test_illegal();
        test_wrap();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
